// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/redirect/busy stall and flush control,
// halt drain/halted FSM, and saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             idex_halt,
  input  logic             ex_redirect,
  input  logic             exmem_regwrite,
  input  logic [4:0]       exmem_rd,
  input  logic             memwb_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic             dmem_busy,
  input  logic             restart,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned    DW         = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_q;
  logic [DW-1:0]    drain_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use_s, halt_go_s, stall_inc_s, flush_inc_s;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic em_we, input logic [4:0] em_rd,
                                         input logic mw_we, input logic [4:0] mw_rd);
    logic [1:0] sel;
    if (em_we && (em_rd != 5'd0) && (em_rd == rs)) begin
      sel = 2'b10;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign forward_a = fwd_sel(idex_rs1, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
  assign forward_b = fwd_sel(idex_rs2, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);

  assign load_use_s = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  // Prioritised pipeline control; a halt in RUN outranks a redirect since both name the EX instruction.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_en     = 1'b1;
    halt_go_s   = 1'b0;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (dmem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_en     = 1'b0;
      stall_inc_s = (state_q == RUN);
    end else if (state_q != RUN) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (idex_halt) begin
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      halt_go_s  = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      flush_inc_s = 1'b1;
    end else if (load_use_s) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_flush  = 1'b1;
      stall_inc_s = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Saturating event counter next-state.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc_s && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end else begin
      stall_d = stall_q;
    end
    if (flush_inc_s && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end else begin
      flush_d = flush_q;
    end
  end

  // Halt FSM, drain counter and event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      drain_q  <= {DW{1'b0}};
      halted_q <= 1'b0;
      stall_q  <= {CNT_W{1'b0}};
      flush_q  <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      case (state_q)
        RUN: begin
          if (halt_go_s) begin
            state_q <= DRAIN;
            drain_q <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (pipe_en) begin
            if (drain_q == {DW{1'b0}}) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end else begin
              drain_q <= drain_q - DW'(1);
            end
          end
        end
        HALTED: begin
          if (restart) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule
